// File: rtl/seq_cp_pkg.sv
// Shared types for the instruction control path: FSM state codes, opcodes,
// decoded instruction classes and trap causes.
package seq_cp_pkg;

  typedef enum logic [2:0] {
    ST_HALT       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_EXEC       = 3'd2,
    ST_WAIT_LOAD  = 3'd3,
    ST_WAIT_STORE = 3'd4,
    ST_TRAP       = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ALU = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_HLT,
    CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_ISEGV   = 3'd1,
    CAUSE_DSEGV   = 3'd2,
    CAUSE_ILLEGAL = 3'd3,
    CAUSE_TIMEOUT = 3'd4
  } cause_t;

  function automatic op_class_t classify(input logic [2:0] op);
    case (op)
      OP_NOP:  return CLS_NOP;
      OP_ALU:  return CLS_ALU;
      OP_LD:   return CLS_LD;
      OP_ST:   return CLS_ST;
      OP_HLT:  return CLS_HLT;
      default: return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/seq_controlpath_if.sv
// Bundle of everything the control path exchanges with memories, datapath and
// the run-control host. master = control path, slave = its environment.
interface seq_controlpath_if #(
  parameter int INSTR_W = 32,
  parameter int RSW     = 4,
  parameter int CNT_W   = 16
);
  // Handshakes: instr is taken in FETCH on the cycle instr_valid is high; a
  // load/store completes on the cycle data_ready is high while ld/st is held.
  // Fault inputs (instr_segv, data_segv) take priority over those completions.
  logic               go;
  logic               step_mode;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_segv;
  logic               data_ready;
  logic               data_segv;
  logic               trap_ack;
  logic [2:0]         state;
  logic [2:0]         opcode;
  logic               form;
  logic [RSW-1:0]     a_sel;
  logic [RSW-1:0]     b_sel;
  logic [RSW-1:0]     c_sel;
  logic               const_c;
  logic               reg_we;
  logic               pc_inc;
  logic               ld;
  logic               st;
  logic               halted;
  logic               trap;
  logic [2:0]         trap_cause;
  logic [CNT_W-1:0]   retire_count;

  modport master (
    input  go, step_mode, instr, instr_valid, instr_segv, data_ready, data_segv, trap_ack,
    output state, opcode, form, a_sel, b_sel, c_sel, const_c, reg_we, pc_inc, ld, st,
           halted, trap, trap_cause, retire_count
  );

  modport slave (
    output go, step_mode, instr, instr_valid, instr_segv, data_ready, data_segv, trap_ack,
    input  state, opcode, form, a_sel, b_sel, c_sel, const_c, reg_we, pc_inc, ld, st,
           halted, trap, trap_cause, retire_count
  );
endinterface

// File: rtl/seq_cp_decode.sv
// Purely combinational instruction-register field split and opcode classing.
import seq_cp_pkg::*;

module seq_cp_decode #(
  parameter int INSTR_W = 32,
  parameter int RSW     = 4
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [2:0]         opcode,
  output logic               form,
  output logic [RSW-1:0]     a_sel,
  output logic [RSW-1:0]     b_sel,
  output logic [RSW-1:0]     c_sel,
  output op_class_t          cls
);
  assign opcode = ir[INSTR_W-1 -: 3];
  assign form   = ir[INSTR_W-4];
  assign a_sel  = ir[INSTR_W-5 -: RSW];
  assign b_sel  = ir[INSTR_W-5-RSW -: RSW];
  assign c_sel  = ir[INSTR_W-5-2*RSW -: RSW];
  assign cls    = classify(opcode);
endmodule

// File: rtl/seq_controlpath.sv
// Instruction fetch/decode/execute sequencer with single-step, stall watchdog,
// trap-cause register and retired-instruction counter.
import seq_cp_pkg::*;

module seq_controlpath #(
  parameter int INSTR_W   = 32,
  parameter int RSW       = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input logic               clk,
  input logic               reset,
  seq_controlpath_if.master bus
);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT);

  state_t               state_q, state_d;
  cause_t               cause_q, cause_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [CNT_W-1:0]     retire_q;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 load_ir, retire, stalled, wd_expired;
  logic                 pc_inc, reg_we, ld, st;
  op_class_t            cls;

  seq_cp_decode #(.INSTR_W(INSTR_W), .RSW(RSW)) u_decode (
    .ir     (ir_q),
    .opcode (bus.opcode),
    .form   (bus.form),
    .a_sel  (bus.a_sel),
    .b_sel  (bus.b_sel),
    .c_sel  (bus.c_sel),
    .cls    (cls)
  );

  assign wd_expired = (TIMEOUT != 0) && (wd_q == TIMEOUT_V);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    load_ir = 1'b0;
    retire  = 1'b0;
    stalled = 1'b0;
    pc_inc  = 1'b0;
    reg_we  = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    case (state_q)
      ST_HALT: if (bus.go) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.instr_segv) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ISEGV;
        end else if (bus.instr_valid) begin
          load_ir = 1'b1;
          state_d = ST_EXEC;
        end else begin
          stalled = 1'b1;
          if (wd_expired) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_NOP, CLS_ALU: begin
            pc_inc  = 1'b1;
            reg_we  = (cls == CLS_ALU);
            retire  = 1'b1;
            state_d = bus.step_mode ? ST_HALT : ST_FETCH;
          end
          CLS_LD: begin
            ld      = 1'b1;
            state_d = ST_WAIT_LOAD;
          end
          CLS_ST: begin
            st      = 1'b1;
            state_d = ST_WAIT_STORE;
          end
          CLS_HLT: begin
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = ST_HALT;
          end
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_WAIT_LOAD, ST_WAIT_STORE: begin
        ld = (state_q == ST_WAIT_LOAD);
        st = (state_q == ST_WAIT_STORE);
        if (bus.data_segv) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DSEGV;
        end else if (bus.data_ready) begin
          pc_inc  = 1'b1;
          reg_we  = (state_q == ST_WAIT_LOAD);
          retire  = 1'b1;
          state_d = bus.step_mode ? ST_HALT : ST_FETCH;
        end else begin
          stalled = 1'b1;
          if (wd_expired) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_TRAP: begin
        if (bus.trap_ack) begin
          state_d = ST_HALT;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Any state change clears the watchdog, so entering FETCH/WAIT_* starts it at zero.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q)
      wd_d = '0;
    else if (stalled && TIMEOUT != 0)
      wd_d = wd_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_HALT;
      cause_q  <= CAUSE_NONE;
      ir_q     <= '0;
      retire_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wd_q    <= wd_d;
      if (load_ir) ir_q <= bus.instr;
      if (retire) retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.state        = state_q;
  assign bus.const_c      = bus.form;
  assign bus.pc_inc       = pc_inc;
  assign bus.reg_we       = reg_we;
  assign bus.ld           = ld;
  assign bus.st           = st;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.trap         = (state_q == ST_TRAP);
  assign bus.trap_cause   = cause_q;
  assign bus.retire_count = retire_q;
endmodule
